// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared state/direction encodings, default timing and button indices.
package count_ctrl_pkg;
  typedef enum logic {ST_PAUSE = 1'b0, ST_RUN = 1'b1} state_e;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_TICK_DIV = 8;
  localparam int BTN_RUN = 0;
  localparam int BTN_DIR = 1;
  localparam int BTN_STEP = 2;
  localparam int BTN_CLR = 3;
endpackage

// File: rtl/count_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stable-run counter and registered press pulse.
module btn_debounce
  import count_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic meta_q, sync_q, level_q, level_d, prev_q, press_q, differ;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    differ = sync_q != level_q;
    cnt_d = (differ && cnt_q != LAST) ? cnt_q + CW'(1) : '0;
    level_d = (differ && cnt_q == LAST) ? sync_q : level_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      level_q <= 1'b0;
      prev_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
      level_q <= level_d;
      prev_q <= level_q;
      press_q <= level_q & ~prev_q;
      cnt_q <= cnt_d;
    end
  end
  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: debounced front panel driving enable/direction/clear of a downstream up/down counter.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int TICK_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_run,
  input  logic btn_dir,
  input  logic btn_step,
  input  logic btn_clr,
  output logic enable,
  output logic direction,
  output logic cnt_rst,
  output logic running
);
  localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(TICK_DIV - 1);
  logic [3:0] btn_raw, press, unused_level;
  state_e state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic en_q, en_d, dir_q, dir_d, clr_q, clr_d, run_q;
  assign btn_raw = {btn_clr, btn_step, btn_dir, btn_run};
  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(btn_raw[i]),
      .level  (unused_level[i]),
      .press  (press[i])
    );
  end
  // clr beats run beats step; dir toggles regardless
  always_comb begin
    state_d = press[BTN_RUN] ? (state_q == ST_RUN ? ST_PAUSE : ST_RUN) : state_q;
    presc_d = presc_q;
    en_d = 1'b0;
    clr_d = press[BTN_CLR];
    dir_d = press[BTN_DIR] ? (dir_q == DIR_UP ? DIR_DOWN : DIR_UP) : dir_q;
    if (press[BTN_CLR] || press[BTN_RUN]) presc_d = '0;
    else if (state_q == ST_RUN) begin
      presc_d = presc_q == PRESC_LAST ? '0 : presc_q + TICK_W'(1);
      en_d = presc_q == PRESC_LAST;
    end else en_d = press[BTN_STEP];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_PAUSE;
      presc_q <= '0;
      en_q <= 1'b0;
      dir_q <= DIR_UP;
      clr_q <= 1'b1;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      en_q <= en_d;
      dir_q <= dir_d;
      clr_q <= clr_d;
      run_q <= state_d == ST_RUN;
    end
  end
  assign enable = en_q;
  assign direction = dir_q;
  assign cnt_rst = clr_q;
  assign running = run_q;
endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed plan plus random button activity against a behavioural model.
module tb_count_ctrl;
  localparam int DEB = 4;
  localparam int TD = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic btn_run = 1'b0, btn_dir = 1'b0, btn_step = 1'b0, btn_clr = 1'b0;
  logic enable, direction, cnt_rst, running;
  logic [3:0] raw;
  int errors = 0, checks = 0;
  bit chk = 1'b0;
  count_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TD), .TICK_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_dir(btn_dir),
    .btn_step(btn_step), .btn_clr(btn_clr), .enable(enable),
    .direction(direction), .cnt_rst(cnt_rst), .running(running)
  );
  always #5 clk = ~clk;
  // model: buttons indexed run=0 dir=1 step=2 clr=3; since = edges spent in RUN since entry/clear
  bit d1[4], d2[4], lvl[4], rose[4], prs[4];
  int cnt[4];
  bit m_en = 1'b0, m_dir = 1'b1, m_clr = 1'b1, m_run = 1'b0;
  int since = 0;
  always @(posedge clk) begin
    raw = {btn_clr, btn_step, btn_dir, btn_run};
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) begin
        d1[b] = 0; d2[b] = 0; lvl[b] = 0; rose[b] = 0; prs[b] = 0; cnt[b] = 0;
      end
      m_en = 0; m_dir = 1; m_clr = 1; m_run = 0; since = 0;
    end else begin
      m_clr = prs[3];
      if (prs[1]) m_dir = !m_dir;
      if (prs[3] || prs[0]) begin
        if (prs[0]) m_run = !m_run;
        since = 0;
        m_en = 0;
      end else if (m_run) begin
        since++;
        m_en = (since % TD) == 0;
      end else m_en = prs[2];
      for (int b = 0; b < 4; b++) begin
        prs[b] = rose[b];
        rose[b] = 0;
        if (d2[b] != lvl[b]) begin
          cnt[b]++;
          if (cnt[b] == DEB) begin
            lvl[b] = d2[b];
            cnt[b] = 0;
            rose[b] = lvl[b];
          end
        end else cnt[b] = 0;
        d2[b] = d1[b];
        d1[b] = raw[b];
      end
    end
  end
  task automatic cmp(string nm, logic a, logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, a, e);
    end
  endtask
  always @(negedge clk) if (chk) begin
    cmp("enable", enable, m_en);
    cmp("direction", direction, m_dir);
    cmp("cnt_rst", cnt_rst, m_clr);
    cmp("running", running, m_run);
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    tick(1);
    chk = 1'b1;
    cmp("rst_cnt_rst", cnt_rst, 1'b1);
    cmp("rst_enable", enable, 1'b0);
    cmp("rst_direction", direction, 1'b1);
    cmp("rst_running", running, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    cmp("release_cnt_rst", cnt_rst, 1'b0);
    btn_run = 1'b1;
    tick(7);
    cmp("run_early", running, 1'b0);
    tick(1);
    cmp("run_entry", running, 1'b1);
    tick(2);
    cmp("first_tick_early", enable, 1'b0);
    btn_run = 1'b0;
    tick(1);
    cmp("first_tick", enable, 1'b1);
    tick(3);
    cmp("second_tick", enable, 1'b1);
    btn_step = 1'b1;
    tick(8);
    btn_step = 1'b0;
    tick(10);
    btn_dir = 1'b1;
    tick(7);
    cmp("dir_early", direction, 1'b1);
    tick(1);
    cmp("dir_down", direction, 1'b0);
    btn_dir = 1'b0;
    tick(12);
    btn_dir = 1'b1;
    tick(8);
    cmp("dir_up", direction, 1'b1);
    btn_dir = 1'b0;
    tick(10);
    n = 0;
    while (enable !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    cmp("wrap_found", enable, 1'b1);
    tick(1);
    btn_clr = 1'b1;
    tick(8);
    cmp("clr_pulse", cnt_rst, 1'b1);
    cmp("clr_no_enable", enable, 1'b0);
    cmp("clr_running", running, 1'b1);
    btn_clr = 1'b0;
    tick(3);
    cmp("clr_next_tick", enable, 1'b1);
    btn_run = 1'b1;
    tick(8);
    cmp("pause", running, 1'b0);
    btn_run = 1'b0;
    tick(10);
    for (int i = 0; i < 6; i++) begin
      btn_run = ~btn_run;
      tick(2);
    end
    btn_run = 1'b0;
    tick(12);
    cmp("bounce_rejected", running, 1'b0);
    btn_step = 1'b1;
    tick(7);
    cmp("step_early", enable, 1'b0);
    tick(1);
    cmp("step_pulse", enable, 1'b1);
    tick(1);
    cmp("step_single", enable, 1'b0);
    btn_step = 1'b0;
    tick(10);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) btn_run = ~btn_run;
      if ($urandom_range(5) == 0) btn_dir = ~btn_dir;
      if ($urandom_range(5) == 0) btn_step = ~btn_step;
      if ($urandom_range(5) == 0) btn_clr = ~btn_clr;
      rst_n = $urandom_range(399) != 0;
      tick(1);
    end
    rst_n = 1'b1;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
